dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: N, default 32, data width; ADDRESS, default 10, word-address width; MAX_LOCK, default 8, maximum consecutive grants under lock.
REQ-002 clk_i  input  1  clock; the only clock in the block.
REQ-003 rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 req0_i/req1_i  input  1  access request from requester 0 (CPU) or requester 1 (DMA).
REQ-005 we0_i/we1_i  input  1  request is a store (1) or a load (0).
REQ-006 lock0_i/lock1_i  input  1  ask to keep ownership on the next cycle (burst).
REQ-007 addr0_i/addr1_i  input  ADDRESS  word address.
REQ-008 wdata0_i/wdata1_i  input  N  store data.
REQ-009 gnt0_o/gnt1_o  output  1  request accepted this cycle (combinational).
REQ-010 rvalid0_o/rvalid1_o  output  1  load data valid; one-cycle pulse.
REQ-011 rdata0_o/rdata1_o  output  N  registered load data.
REQ-012 mem_addr_o  output  ADDRESS  address to the data memory.
REQ-013 mem_st_data_o  output  N  store data to the memory.
REQ-014 mem_st_en_o  output  1  store enable to the memory.
REQ-015 mem_ld_data_i  input  N  combinational read data from the memory.

Function
REQ-016 At most one gnt SHALL be high in any cycle; a gnt SHALL be high only when the matching req is high.
REQ-017 The FSM states SHALL be IDLE, OWN0 and OWN1; the state names the requester granted in the previous cycle (IDLE = no grant).
REQ-018 With one requester active, that requester SHALL be granted in the same cycle (zero wait).
REQ-019 With both requesters active and no lock in force, the requester not granted most recently SHALL win (round-robin); from IDLE after reset, requester 0 SHALL win.
REQ-020 In OWNx with lockx_i high on the previous grant and reqx_i high, requester x SHALL keep the grant even if the other requester is active.
REQ-021 A lock counter SHALL count consecutive locked grants; at MAX_LOCK, if the other requester is active, the grant SHALL pass to it for at least one cycle; the counter SHALL clear on any owner change or on IDLE.
REQ-022 The mem_* outputs SHALL mux the granted requester's addr/wdata; mem_st_en_o = gnt & we; with no grant, mem_st_en_o SHALL be 0 and mem_addr_o SHALL hold the last value.
REQ-023 A granted load SHALL capture mem_ld_data_i into rdatax_o at the clock edge, and rvalidx_o SHALL pulse high for the following cycle only (latency 1).
REQ-024 Granted stores SHALL NOT generate rvalid.
REQ-025 Back-to-back loads SHALL yield one rvalid per cycle with no bubble.
REQ-026 A request dropped without a grant SHALL leave no state effect.

Reset
REQ-027 On rst_ni low, the block SHALL enter IDLE, clear the lock counter, set the round-robin pointer to favour requester 0, clear rvalid0_o/rvalid1_o and rdata0_o/rdata1_o, and force mem_addr_o to 0 and mem_st_en_o to 0, asynchronously.
REQ-028 A reset during a burst SHALL abandon the burst; no rvalid SHALL appear for a load granted in the cycle in which reset asserts.

Structure
REQ-029 The state enum (IDLE/OWN0/OWN1) and the lock-counter width ($clog2(MAX_LOCK+1)) SHALL reside in a shared package dmem_arb_pkg.
REQ-030 The two-way round-robin pick SHALL be one sub-module, dmem_arb_rr (inputs: req vector, last owner, lock-in-force; output: one-hot grant).
REQ-031 The block SHALL connect directly to the data memory port without extra buffering; the expected RTL size is 150-300 lines.

Verification
REQ-032 Reset, then req0 only: store addr 5 = 0xDEADBEEF, then load addr 5 -> gnt0 both cycles, mem_st_en pulses once, rvalid0 the cycle after the load with rdata0 = 0xDEADBEEF.
REQ-033 Both requesters load continuously, no lock -> grants alternate 0,1,0,1 starting with 0; each rvalid follows its gnt by exactly 1 cycle.
REQ-034 req1 holds lock1 for a 20-cycle burst while req0 is held -> gnt1 for 8 cycles, gnt0 for 1 cycle, then gnt1 resumes; this pattern repeats.
REQ-035 Simultaneous store by 0 and load by 1 to the same address 3 -> the loser sees the winner's effect (load after the store returns the new data; a load before the store returns the old data).
REQ-036 rst_ni pulled low mid-burst with a load granted -> outputs clear immediately, no rvalid, FSM returns to IDLE, and the next contention is won by requester 0.
REQ-037 Random two-requester traffic against a reference memory model -> zero data mismatches, never two gnts in one cycle, and no wait exceeding MAX_LOCK+1 cycles.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: owner state and lock-counter sizing.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    function automatic int lock_cnt_w(int max_lock);
        return $clog2(max_lock + 1);
    endfunction

    localparam int MAX_LOCK_DEF = 8;
    localparam int LOCK_CNT_W   = lock_cnt_w(MAX_LOCK_DEF);

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's port onto the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int N       = 32,
    parameter int ADDRESS = 10
);
    logic               req;
    logic               we;
    logic               lock;
    logic [ADDRESS-1:0] addr;
    logic [N-1:0]       wdata;
    logic               gnt;
    logic               rvalid;
    logic [N-1:0]       rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin pick with an owner-hold override.
module dmem_arb_rr (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       lock_i,
    output logic [1:0] gnt_o
);
    logic win1;

    // Under contention the held owner keeps it, otherwise the other side wins
    assign win1 = lock_i ? last_i : ~last_i;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = win1 ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end
endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter onto a single-port data memory with bounded burst locking.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N        = 32,
    parameter int ADDRESS  = 10,
    parameter int MAX_LOCK = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req0_i,
    input  logic               req1_i,
    input  logic               we0_i,
    input  logic               we1_i,
    input  logic               lock0_i,
    input  logic               lock1_i,
    input  logic [ADDRESS-1:0] addr0_i,
    input  logic [ADDRESS-1:0] addr1_i,
    input  logic [N-1:0]       wdata0_i,
    input  logic [N-1:0]       wdata1_i,
    output logic               gnt0_o,
    output logic               gnt1_o,
    output logic               rvalid0_o,
    output logic               rvalid1_o,
    output logic [N-1:0]       rdata0_o,
    output logic [N-1:0]       rdata1_o,
    output logic [ADDRESS-1:0] mem_addr_o,
    output logic [N-1:0]       mem_st_data_o,
    output logic               mem_st_en_o,
    input  logic [N-1:0]       mem_ld_data_i
);
    localparam int LW = lock_cnt_w(MAX_LOCK);
    localparam logic [LW-1:0] LOCK_MAX = LW'(MAX_LOCK);

    arb_state_e         state_q, state_d;
    logic               last_q, last_d;
    logic               lock_q, lock_d;
    logic [LW-1:0]      cnt_q, cnt_d;
    logic [LW-1:0]      cnt_inc;
    logic [1:0]         rr_gnt, gnt;
    logic               lock_hold;
    logic [ADDRESS-1:0] addr_q;
    logic               ld0, ld1;

    always_comb begin
        lock_hold = 1'b0;
        unique case (state_q)
            OWN0:    lock_hold = lock_q && req0_i && (cnt_q < LOCK_MAX);
            OWN1:    lock_hold = lock_q && req1_i && (cnt_q < LOCK_MAX);
            default: lock_hold = 1'b0;
        endcase
    end

    dmem_arb_rr u_rr (
        .req_i  ({req1_i, req0_i}),
        .last_i (last_q),
        .lock_i (lock_hold),
        .gnt_o  (rr_gnt)
    );

    // Reset masks grants so nothing reaches the memory while rst_ni is low
    assign gnt    = rst_ni ? rr_gnt : 2'b00;
    assign gnt0_o = gnt[0];
    assign gnt1_o = gnt[1];

    assign cnt_inc = (cnt_q == LOCK_MAX) ? cnt_q : cnt_q + LW'(1);

    always_comb begin
        state_d = IDLE;
        last_d  = last_q;
        lock_d  = 1'b0;
        cnt_d   = '0;
        unique case (1'b1)
            gnt[0]: begin
                state_d = OWN0;
                last_d  = 1'b0;
                lock_d  = lock0_i;
                cnt_d   = (state_q == OWN0 && lock_q) ? cnt_inc : LW'(1);
            end
            gnt[1]: begin
                state_d = OWN1;
                last_d  = 1'b1;
                lock_d  = lock1_i;
                cnt_d   = (state_q == OWN1 && lock_q) ? cnt_inc : LW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_addr_o    = gnt[1] ? addr1_i :
                           gnt[0] ? addr0_i : addr_q;
    assign mem_st_data_o = gnt[1] ? wdata1_i : wdata0_i;
    assign mem_st_en_o   = (gnt[0] & we0_i) | (gnt[1] & we1_i);

    assign ld0 = gnt[0] & ~we0_i;
    assign ld1 = gnt[1] & ~we1_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q    <= '0;
            rvalid0_o <= 1'b0;
            rvalid1_o <= 1'b0;
            rdata0_o  <= '0;
            rdata1_o  <= '0;
        end else begin
            addr_q    <= mem_addr_o;
            rvalid0_o <= ld0;
            rvalid1_o <= ld1;
            if (ld0) rdata0_o <= mem_ld_data_i;
            if (ld1) rdata1_o <= mem_ld_data_i;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus random traffic.
module tb_dmem_arbiter;
    localparam int N        = 32;
    localparam int ADDRESS  = 10;
    localparam int MAX_LOCK = 8;
    localparam int DEPTH    = 1 << ADDRESS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.N(N), .ADDRESS(ADDRESS)) r0 ();
    dmem_arbiter_if #(.N(N), .ADDRESS(ADDRESS)) r1 ();

    logic [ADDRESS-1:0] mem_addr;
    logic [N-1:0]       mem_st_data;
    logic [N-1:0]       mem_ld_data;
    logic               mem_st_en;
    bit   [N-1:0]       mem [DEPTH];

    dmem_arbiter #(.N(N), .ADDRESS(ADDRESS), .MAX_LOCK(MAX_LOCK)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req0_i        (r0.req),
        .req1_i        (r1.req),
        .we0_i         (r0.we),
        .we1_i         (r1.we),
        .lock0_i       (r0.lock),
        .lock1_i       (r1.lock),
        .addr0_i       (r0.addr),
        .addr1_i       (r1.addr),
        .wdata0_i      (r0.wdata),
        .wdata1_i      (r1.wdata),
        .gnt0_o        (r0.gnt),
        .gnt1_o        (r1.gnt),
        .rvalid0_o     (r0.rvalid),
        .rvalid1_o     (r1.rvalid),
        .rdata0_o      (r0.rdata),
        .rdata1_o      (r1.rdata),
        .mem_addr_o    (mem_addr),
        .mem_st_data_o (mem_st_data),
        .mem_st_en_o   (mem_st_en),
        .mem_ld_data_i (mem_ld_data)
    );

    assign mem_ld_data = mem[mem_addr];
    always @(posedge clk) if (mem_st_en) mem[mem_addr] <= mem_st_data;

    typedef struct {
        logic [1:0]         gnt;
        logic               st_en;
        logic [ADDRESS-1:0] addr;
        logic [N-1:0]       sdata;
    } exp_t;

    typedef struct {
        int           cyc;
        logic [N-1:0] data;
    } rd_t;

    exp_t gnt_q[$];
    rd_t  rd0_q[$];
    rd_t  rd1_q[$];
    logic [1:0] hist[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: who won last, current run length and lock
    int                 m_prev;
    bit                 m_prev_lock;
    int                 m_run;
    bit                 m_last;
    logic [ADDRESS-1:0] m_addr;
    bit   [N-1:0]       ref_mem [DEPTH];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_prev      = -1;
        m_prev_lock = 1'b0;
        m_run       = 0;
        m_last      = 1'b1;
        m_addr      = '0;
        gnt_q.delete();
        rd0_q.delete();
        rd1_q.delete();
    endfunction

    task automatic issue(
        input bit q0, input bit w0, input bit l0,
        input logic [ADDRESS-1:0] a0, input logic [N-1:0] d0,
        input bit q1, input bit w1, input bit l1,
        input logic [ADDRESS-1:0] a1, input logic [N-1:0] d1,
        output int win
    );
        exp_t               e;
        rd_t                r;
        logic [ADDRESS-1:0] a;
        logic [N-1:0]       d;
        bit                 w, l;
        r0.req = q0; r0.we = w0; r0.lock = l0; r0.addr = a0; r0.wdata = d0;
        r1.req = q1; r1.we = w1; r1.lock = l1; r1.addr = a1; r1.wdata = d1;
        win = -1;
        if (q0 && q1) begin
            if (m_prev >= 0 && m_prev_lock && m_run < MAX_LOCK) win = m_prev;
            else win = m_last ? 0 : 1;
        end else if (q0) win = 0;
        else if (q1) win = 1;
        e.gnt   = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
        e.st_en = 1'b0;
        e.sdata = '0;
        if (win >= 0) begin
            a = (win == 1) ? a1 : a0;
            d = (win == 1) ? d1 : d0;
            w = (win == 1) ? w1 : w0;
            l = (win == 1) ? l1 : l0;
            m_addr  = a;
            e.st_en = w;
            e.sdata = d;
            if (w) ref_mem[a] = d;
            else begin
                r.cyc  = cyc + 1;
                r.data = ref_mem[a];
                if (win == 0) rd0_q.push_back(r);
                else rd1_q.push_back(r);
            end
            if (win == m_prev && m_prev_lock)
                m_run = (m_run < MAX_LOCK) ? m_run + 1 : MAX_LOCK;
            else
                m_run = 1;
            m_prev      = win;
            m_prev_lock = l;
            m_last      = (win == 1);
        end else begin
            m_prev      = -1;
            m_prev_lock = 1'b0;
            m_run       = 0;
        end
        e.addr = m_addr;
        gnt_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(
        input bit q0, input bit w0, input bit l0,
        input logic [ADDRESS-1:0] a0, input logic [N-1:0] d0,
        input bit q1, input bit w1, input bit l1,
        input logic [ADDRESS-1:0] a1, input logic [N-1:0] d1
    );
        int win;
        issue(q0, w0, l0, a0, d0, q1, w1, l1, a1, d1, win);
        step();
    endtask

    task automatic idle();
        drv(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    // mid=1 drops reset in the middle of an already issued cycle
    task automatic reset_now(input bit mid);
        if (mid) #2;
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", {r1.gnt, r0.gnt}, 2'b00);
        chk("rst_st_en", mem_st_en, 1'b0);
        chk("rst_addr", mem_addr, '0);
        chk("rst_rvalid", {r1.rvalid, r0.rvalid}, 2'b00);
        chk("rst_rdata0", r0.rdata, '0);
        chk("rst_rdata1", r1.rdata, '0);
        model_reset();
        step();
        chk("rst_rvalid_after_edge", {r1.rvalid, r0.rvalid}, 2'b00);
        rst_n = 1'b1;
    endtask

    task automatic chk_rd(input int w, input logic rv, input logic [N-1:0] rd);
        rd_t   r;
        int    n;
        string nm;
        n  = (w == 0) ? rd0_q.size() : rd1_q.size();
        nm = $sformatf("rvalid%0d", w);
        if (rv) begin
            if (n == 0) chk({nm, "_spurious"}, rv, 1'b0);
            else begin
                if (w == 0) r = rd0_q.pop_front();
                else r = rd1_q.pop_front();
                chk({nm, "_cycle"}, cyc, r.cyc);
                chk($sformatf("rdata%0d", w), rd, r.data);
            end
        end else if (n != 0) begin
            if (w == 0) r = rd0_q[0];
            else r = rd1_q[0];
            if (r.cyc <= cyc) begin
                chk({nm, "_missing"}, rv, 1'b1);
                if (w == 0) void'(rd0_q.pop_front());
                else void'(rd1_q.pop_front());
            end
        end
    endtask

    // Monitor: compares the DUT against queued expectations mid-cycle
    initial begin
        exp_t me;
        int   wt0, wt1;
        wt0 = 0;
        wt1 = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wt0 = 0;
                wt1 = 0;
            end else begin
                if (gnt_q.size() != 0) begin
                    me = gnt_q.pop_front();
                    chk("gnt", {r1.gnt, r0.gnt}, me.gnt);
                    chk("mem_st_en", mem_st_en, me.st_en);
                    chk("mem_addr", mem_addr, me.addr);
                    if (me.st_en) chk("mem_st_data", mem_st_data, me.sdata);
                end
                chk("two_gnts", r0.gnt & r1.gnt, 1'b0);
                chk_rd(0, r0.rvalid, r0.rdata);
                chk_rd(1, r1.rvalid, r1.rdata);
                wt0 = (r0.req && !r0.gnt) ? wt0 + 1 : 0;
                wt1 = (r1.req && !r1.gnt) ? wt1 + 1 : 0;
                if (wt0 != 0) chk("wait0_bound", wt0 > MAX_LOCK + 1, 1'b0);
                if (wt1 != 0) chk("wait1_bound", wt1 > MAX_LOCK + 1, 1'b0);
                hist.push_back({r1.gnt, r0.gnt});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit                 q[2], w[2], l[2], pend[2];
        logic [ADDRESS-1:0] a[2];
        logic [N-1:0]       d[2];
        int                 win;
        r0.req = 0; r0.we = 0; r0.lock = 0; r0.addr = '0; r0.wdata = '0;
        r1.req = 0; r1.we = 0; r1.lock = 0; r1.addr = '0; r1.wdata = '0;
        model_reset();
        #1;
        reset_now(0);

        // single requester: store then load at address 5
        hist.delete();
        drv(1, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        chk("dir_rvalid0", r0.rvalid, 1'b1);
        chk("dir_rdata0", r0.rdata, 32'hDEADBEEF);
        idle();
        chk("dir_gnt_store", hist[0], 2'b01);
        chk("dir_gnt_load", hist[1], 2'b01);

        // continuous contention, no lock: strict alternation from 0
        reset_now(0);
        hist.delete();
        for (int i = 0; i < 8; i++)
            drv(1, 0, 0, ADDRESS'(i), 0, 1, 0, 0, ADDRESS'(i + 16), 0);
        idle();
        for (int i = 0; i < 8; i++)
            chk($sformatf("rr_alt[%0d]", i), hist[i], (i % 2 == 1) ? 2'b10 : 2'b01);

        // locked burst from 1 against a persistent requester 0
        reset_now(0);
        hist.delete();
        drv(0, 0, 0, 0, 0, 1, 0, 1, 40, 0);
        for (int i = 0; i < 20; i++)
            drv(1, 0, 0, 50, 0, 1, 0, 1, ADDRESS'(41 + i), 0);
        idle();
        for (int i = 0; i < 21; i++)
            chk($sformatf("burst[%0d]", i), hist[i],
                (i % (MAX_LOCK + 1) == MAX_LOCK) ? 2'b01 : 2'b10);

        // store/load race on address 3, both orders
        reset_now(0);
        drv(1, 1, 0, 3, 32'h11112222, 1, 0, 0, 3, 0);
        drv(0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
        chk("race_after_store", r1.rdata, 32'h11112222);
        drv(1, 0, 0, 7, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 0, 3, 32'h33334444, 1, 0, 0, 3, 0);
        chk("race_before_store_v", r1.rvalid, 1'b1);
        chk("race_before_store", r1.rdata, 32'h11112222);
        drv(1, 1, 0, 3, 32'h33334444, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
        chk("race_new_data", r1.rdata, 32'h33334444);
        idle();

        // reset in the middle of a locked load burst
        reset_now(0);
        drv(0, 0, 0, 0, 0, 1, 0, 1, 60, 0);
        for (int i = 0; i < 3; i++) drv(1, 0, 0, 61, 0, 1, 0, 1, 62, 0);
        issue(1, 0, 0, 63, 0, 1, 0, 1, 64, 0, win);
        reset_now(1);
        hist.delete();
        drv(1, 0, 0, 65, 0, 1, 0, 0, 66, 0);
        chk("post_reset_winner", hist[0], 2'b01);
        idle();

        // random two-requester traffic
        for (int k = 0; k < 2; k++) begin
            q[k] = 0; w[k] = 0; l[k] = 0; pend[k] = 0; a[k] = '0; d[k] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (pend[k]) begin
                    if ($urandom_range(9) == 0) q[k] = 0;
                end else begin
                    q[k] = ($urandom_range(9) < (l[k] ? 9 : 6));
                    w[k] = 1'($urandom_range(1));
                    l[k] = ($urandom_range(2) == 0);
                    a[k] = ADDRESS'($urandom_range(15));
                    d[k] = $urandom;
                end
            end
            issue(q[0], w[0], l[0], a[0], d[0], q[1], w[1], l[1], a[1], d[1], win);
            pend[0] = q[0] && (win != 0);
            pend[1] = q[1] && (win != 1);
            step();
        end
        repeat (3) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
